// File: rtl/pm_noc_fifo_endpoint.sv
// NoC-clock half of the PM<->NoC async FIFO pair: owns pm_in storage and drains pm_out.
// Gray pointers cross domains through 2-FF synchronizers; all state is on clk_noc_i.
module pm_noc_fifo_endpoint #(
  parameter int unsigned PACKET_SIZE = 128,
  parameter int unsigned AWIDTH      = 2
) (
  input  logic                   clk_noc_i,
  input  logic                   reset_noc_i,
  input  logic                   noc_rx_valid_i,
  input  logic [PACKET_SIZE-1:0] noc_rx_data_i,
  output logic                   noc_rx_ready_o,
  output logic [PACKET_SIZE-1:0] noc_fifo_pm_in_data_o,
  input  logic [AWIDTH:0]        noc_fifo_pm_in_raddr_i,
  output logic [AWIDTH:0]        noc_fifo_pm_in_waddr_o,
  input  logic [PACKET_SIZE-1:0] noc_fifo_pm_out_data_i,
  output logic [AWIDTH:0]        noc_fifo_pm_out_raddr_o,
  input  logic [AWIDTH:0]        noc_fifo_pm_out_waddr_i,
  output logic                   noc_tx_valid_o,
  output logic [PACKET_SIZE-1:0] noc_tx_data_o,
  input  logic                   noc_tx_ready_i
);

  localparam int unsigned DEPTH = 1 << AWIDTH;
  typedef logic [AWIDTH:0] ptr_t;
  // Full pattern: top two gray bits inverted relative to the synced read pointer.
  localparam ptr_t FULL_MASK = ptr_t'(3) << (AWIDTH - 1);

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b = g;
    for (int unsigned i = 1; i <= AWIDTH; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

  // ---------------- write side (pm_in FIFO) ----------------
  logic [PACKET_SIZE-1:0] mem_q [DEPTH];
  ptr_t wptr_q, wptr_d;
  ptr_t waddr_q, waddr_d;
  ptr_t rsync1_q, rsync2_q;
  ptr_t pm_rbin;
  logic full;
  logic push;

  assign full    = (waddr_q == (rsync2_q ^ FULL_MASK));
  assign push    = noc_rx_valid_i & ~full;
  assign pm_rbin = gray2bin(noc_fifo_pm_in_raddr_i);

  always_comb begin
    wptr_d  = wptr_q;
    waddr_d = waddr_q;
    if (push) begin
      wptr_d  = wptr_q + ptr_t'(1);
      waddr_d = bin2gray(wptr_d);
    end
  end

  always_ff @(posedge clk_noc_i) begin
    if (reset_noc_i) begin
      wptr_q   <= '0;
      waddr_q  <= '0;
      rsync1_q <= '0;
      rsync2_q <= '0;
    end else begin
      wptr_q   <= wptr_d;
      waddr_q  <= waddr_d;
      rsync1_q <= noc_fifo_pm_in_raddr_i;
      rsync2_q <= rsync1_q;
    end
  end

  // Storage is not reset; the write lands on the same edge the gray pointer advances.
  always_ff @(posedge clk_noc_i) begin
    if (!reset_noc_i && push) begin
      mem_q[wptr_q[AWIDTH-1:0]] <= noc_rx_data_i;
    end
  end

  assign noc_rx_ready_o         = ~full;
  assign noc_fifo_pm_in_waddr_o = waddr_q;
  assign noc_fifo_pm_in_data_o  = mem_q[pm_rbin[AWIDTH-1:0]];

  // ---------------- read side (pm_out FIFO) ----------------
  ptr_t rptr_q, rptr_d;
  ptr_t raddr_q, raddr_d;
  ptr_t wsync1_q, wsync2_q;
  logic                   tx_valid_q, tx_valid_d;
  logic [PACKET_SIZE-1:0] tx_data_q, tx_data_d;
  logic empty;
  logic load;

  assign empty = (raddr_q == wsync2_q);
  assign load  = ~empty & (~tx_valid_q | noc_tx_ready_i);

  always_comb begin
    rptr_d     = rptr_q;
    raddr_d    = raddr_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    if (load) begin
      tx_data_d  = noc_fifo_pm_out_data_i;
      tx_valid_d = 1'b1;
      rptr_d     = rptr_q + ptr_t'(1);
      raddr_d    = bin2gray(rptr_d);
    end else if (noc_tx_ready_i) begin
      tx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_noc_i) begin
    if (reset_noc_i) begin
      rptr_q     <= '0;
      raddr_q    <= '0;
      wsync1_q   <= '0;
      wsync2_q   <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      rptr_q     <= rptr_d;
      raddr_q    <= raddr_d;
      wsync1_q   <= noc_fifo_pm_out_waddr_i;
      wsync2_q   <= wsync1_q;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign noc_fifo_pm_out_raddr_o = raddr_q;
  assign noc_tx_valid_o          = tx_valid_q;
  assign noc_tx_data_o           = tx_data_q;

endmodule

// File: tb/tb_pm_noc_fifo_endpoint.sv
// Directed bench for pm_noc_fifo_endpoint (AWIDTH=2): reset, fill/full, sync latency,
// drain, backpressure, random two-way traffic with wrap, and mid-burst reset.
module tb_pm_noc_fifo_endpoint;

  logic         clk = 1'b0;
  logic         reset;
  logic         rx_valid;
  logic [127:0] rx_data;
  logic         rx_ready;
  logic [127:0] pm_in_data;
  logic [2:0]   raddr_i;
  logic [2:0]   waddr_o;
  logic [127:0] pm_out_data;
  logic [2:0]   raddr_o;
  logic [2:0]   waddr_i;
  logic         tx_valid;
  logic [127:0] tx_data;
  logic         tx_ready;

  int total = 0;
  int bad   = 0;

  logic [127:0] pm_out_mem [4];
  logic [127:0] q_in[$];
  logic [127:0] q_out[$];
  logic [2:0]   rd_slot;

  always #5 clk = ~clk;

  pm_noc_fifo_endpoint #(.PACKET_SIZE(128), .AWIDTH(2)) dut (
    .clk_noc_i              (clk),
    .reset_noc_i            (reset),
    .noc_rx_valid_i         (rx_valid),
    .noc_rx_data_i          (rx_data),
    .noc_rx_ready_o         (rx_ready),
    .noc_fifo_pm_in_data_o  (pm_in_data),
    .noc_fifo_pm_in_raddr_i (raddr_i),
    .noc_fifo_pm_in_waddr_o (waddr_o),
    .noc_fifo_pm_out_data_i (pm_out_data),
    .noc_fifo_pm_out_raddr_o(raddr_o),
    .noc_fifo_pm_out_waddr_i(waddr_i),
    .noc_tx_valid_o         (tx_valid),
    .noc_tx_data_o          (tx_data),
    .noc_tx_ready_i         (tx_ready)
  );

  function automatic logic [2:0] b2g(input logic [2:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [2:0] g2b(input logic [2:0] g);
    logic [2:0] b;
    b[2] = g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

  // PM-side storage of the pm_out FIFO, addressed by our read pointer.
  always_comb begin
    rd_slot     = g2b(raddr_o);
    pm_out_data = pm_out_mem[rd_slot[1:0]];
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] PA = 128'hA0A0_0001, PB = 128'hB0B0_0002, PC = 128'hC0C0_0003;
  localparam logic [127:0] PD = 128'hD0D0_0004, PE = 128'hE0E0_0005;
  localparam logic [127:0] PX = 128'h1111_0006, PY = 128'h2222_0007, PZ = 128'h3333_0008;
  localparam logic [127:0] PW = 128'h4444_0009, PP = 128'h5555_000A;

  initial begin
    logic [127:0] pk [4];
    logic [2:0]   wg [4];
    logic [2:0]   pm_rbin, pm_wbin, diff, rb;
    logic         acc;
    logic [127:0] val;
    int           sent, made, cyc;

    pk = '{PA, PB, PC, PD};
    wg = '{3'b001, 3'b011, 3'b010, 3'b110};
    pm_out_mem = '{PX, PY, PZ, PW};

    // 1. reset
    reset = 1'b1; rx_valid = 1'b0; rx_data = '0; raddr_i = '0; waddr_i = '0; tx_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_rx_ready", rx_ready, 1);
    check("rst_waddr", waddr_o, 0);
    check("rst_raddr", raddr_o, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);

    // 2. fill the pm_in FIFO
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1'b1; rx_data = pk[i];
      tick();
      check("fill_waddr", waddr_o, wg[i]);
    end
    check("full_ready", rx_ready, 0);
    check("pm_in_slot0", pm_in_data, PA);
    rx_data = PE;
    for (int i = 0; i < 3; i++) tick();
    check("full_hold_waddr", waddr_o, 3'b110);
    check("full_hold_ready", rx_ready, 0);
    check("full_no_write", pm_in_data, PA);

    // 3. PM pops one entry
    raddr_i = 3'b001;
    tick();
    check("rsync_lag_ready", rx_ready, 0);
    tick();
    check("rsync_ready", rx_ready, 1);
    tick();
    check("e_accept_waddr", waddr_o, 3'b111);
    check("e_full_again", rx_ready, 0);
    rx_valid = 1'b0;
    check("pm_in_slot1", pm_in_data, PB);

    // 4. drain three entries
    tx_ready = 1'b1;
    waddr_i  = 3'b010;
    tick();
    check("wsync_lag1", tx_valid, 0);
    tick();
    check("wsync_lag2", tx_valid, 0);
    tick();
    check("tx_x_valid", tx_valid, 1);
    check("tx_x_data", tx_data, PX);
    check("tx_x_raddr", raddr_o, 3'b001);
    tick();
    check("tx_y_data", tx_data, PY);
    check("tx_y_raddr", raddr_o, 3'b011);
    tick();
    check("tx_z_data", tx_data, PZ);
    check("tx_z_raddr", raddr_o, 3'b010);
    check("tx_z_valid", tx_valid, 1);
    tick();
    check("drained_valid", tx_valid, 0);
    check("drained_raddr", raddr_o, 3'b010);

    // 5. backpressure
    pm_out_mem[0] = PP;
    tx_ready = 1'b0;
    waddr_i  = 3'b111;
    tick(); tick(); tick();
    check("bp_valid", tx_valid, 1);
    check("bp_data", tx_data, PW);
    check("bp_raddr", raddr_o, 3'b110);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", tx_valid, 1);
      check("bp_hold_data", tx_data, PW);
      check("bp_hold_raddr", raddr_o, 3'b110);
    end
    tx_ready = 1'b1;
    tick();
    check("bp_next_data", tx_data, PP);
    check("bp_next_raddr", raddr_o, 3'b111);
    tick();
    check("bp_empty_valid", tx_valid, 0);

    // 6. random traffic both ways
    q_in = '{PB, PC, PD, PE};
    pm_rbin = 3'd1; pm_wbin = 3'd5;
    sent = 0; made = 0; cyc = 0;
    while ((sent < 40 || made < 40 || q_in.size() != 0 || q_out.size() != 0) && cyc < 3000) begin
      cyc++;
      if (!rx_valid && sent < 40 && $urandom_range(0, 3) != 0) begin
        rx_valid = 1'b1;
        rx_data  = {$urandom, $urandom, $urandom, $urandom};
      end
      acc = rx_valid & rx_ready;
      if (acc) begin
        q_in.push_back(rx_data);
        sent++;
      end
      if (b2g(pm_rbin) != waddr_o && q_in.size() != 0 && $urandom_range(0, 2) != 0) begin
        check("rand_pm_in_data", pm_in_data, q_in.pop_front());
        pm_rbin = pm_rbin + 3'd1;
        raddr_i = b2g(pm_rbin);
      end
      rb   = g2b(raddr_o);
      diff = pm_wbin - rb;
      if (made < 40 && diff < 3'd4 && $urandom_range(0, 2) != 0) begin
        val = {$urandom, $urandom, $urandom, $urandom};
        pm_out_mem[pm_wbin[1:0]] = val;
        q_out.push_back(val);
        pm_wbin = pm_wbin + 3'd1;
        waddr_i = b2g(pm_wbin);
        made++;
      end
      tx_ready = 1'($urandom_range(0, 1));
      if (tx_valid && tx_ready) begin
        check("rand_tx_data", tx_data, q_out.pop_front());
      end
      tick();
      if (acc) rx_valid = 1'b0;
    end
    check("rand_done", (cyc < 3000) ? 1 : 0, 1);
    check("rand_waddr_wrap", waddr_o, 3'b111);
    check("rand_raddr_wrap", raddr_o, 3'b111);

    // 6b. reset mid-burst
    rx_valid = 1'b1; rx_data = 128'hDEAD_BEEF;
    tx_ready = 1'b0;
    pm_wbin  = pm_wbin + 3'd2;
    waddr_i  = b2g(pm_wbin);
    tick(); tick(); tick(); tick();
    check("pre_rst_tx_valid", tx_valid, 1);
    check("pre_rst_waddr", waddr_o, 3'b001);
    reset = 1'b1; raddr_i = '0; waddr_i = '0; tx_ready = 1'b1;
    tick();
    check("mid_rst_waddr", waddr_o, 0);
    check("mid_rst_raddr", raddr_o, 0);
    check("mid_rst_tx_valid", tx_valid, 0);
    check("mid_rst_tx_data", tx_data, 0);
    reset = 1'b0; rx_valid = 1'b0;
    tick();
    check("post_rst_ready", rx_ready, 1);
    check("post_rst_tx_valid", tx_valid, 0);
    check("post_rst_waddr", waddr_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
